// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronised rising edges of sig_in_i over a window of
// CLK_FREQ/GATE_HZ clocks. Define FREQ_METER_PERIOD_EN to add edge-to-edge period measurement.
module freq_meter #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned GATE_HZ  = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sig_in_i,
    output logic [CNT_W-1:0] freq_cnt_o,
    output logic             valid_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] period_cnt_o
);

    localparam int unsigned      G      = CLK_FREQ / GATE_HZ;
    localparam int unsigned      GW     = (G > 1) ? $clog2(G) : 1;
    localparam logic [GW-1:0]    GLast  = GW'(G - 1);
    localparam logic [GW-1:0]    GOne   = GW'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [0:0] {StIdle, StGate} state_e;

    logic s1_q, s2_q, s3_q;
    logic edge_w;

    state_e           state_q, state_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic             wovf_q, wovf_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    // Two flops resolve metastability; the third gives the previous level for edge detect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_w = s2_q & ~s3_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            gcnt_q  <= '0;
            ecnt_q  <= '0;
            wovf_q  <= 1'b0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            ecnt_q  <= ecnt_d;
            wovf_q  <= wovf_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        ecnt_d  = ecnt_q;
        wovf_d  = wovf_q;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                gcnt_d = '0;
                ecnt_d = '0;
                wovf_d = 1'b0;
                if (en_i) begin
                    state_d = StGate;
                end
            end
            StGate: begin
                if (!en_i) begin
                    state_d = StIdle;
                    gcnt_d  = '0;
                    ecnt_d  = '0;
                    wovf_d  = 1'b0;
                end else if (gcnt_q == GLast) begin
                    // An edge landing in the terminal cycle still belongs to this window.
                    freq_d  = (edge_w && ecnt_q != CntMax) ? ecnt_q + CntOne : ecnt_q;
                    ovf_d   = wovf_q | (edge_w & (ecnt_q == CntMax));
                    valid_d = 1'b1;
                    gcnt_d  = '0;
                    ecnt_d  = '0;
                    wovf_d  = 1'b0;
                end else begin
                    gcnt_d = gcnt_q + GOne;
                    if (edge_w) begin
                        if (ecnt_q == CntMax) begin
                            wovf_d = 1'b1;
                        end else begin
                            ecnt_d = ecnt_q + CntOne;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign freq_cnt_o = freq_q;
    assign valid_o    = valid_q;
    assign ovf_o      = ovf_q;
    assign busy_o     = (state_q == StGate);

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             armed_q, armed_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q   <= '0;
            period_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            period_q <= period_d;
            armed_q  <= armed_d;
        end
    end

    // armed_q marks that an edge has been seen since en rose, so the count is a real period.
    always_comb begin
        pcnt_d   = pcnt_q;
        period_d = period_q;
        armed_d  = armed_q;
        if (!en_i) begin
            pcnt_d  = '0;
            armed_d = 1'b0;
        end else if (edge_w) begin
            if (armed_q) begin
                period_d = (pcnt_q == CntMax) ? CntMax : pcnt_q + CntOne;
            end
            pcnt_d  = '0;
            armed_d = 1'b1;
        end else if (pcnt_q != CntMax) begin
            pcnt_d = pcnt_q + CntOne;
        end
    end

    assign period_cnt_o = period_q;
`else
    assign period_cnt_o = '0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: directed cases plus randomized sig_in/en/rst, checked every cycle
// against an edge-counting window model. Two instances cover CNT_W=32 and CNT_W=4.
module tb_freq_meter;

    localparam int unsigned G = 100;
`ifdef FREQ_METER_PERIOD_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    logic        clk, rst, en, sig_in;
    logic [31:0] freq32, per32;
    logic [3:0]  freq4, per4;
    logic        valid32, valid4, ovf32, ovf4, busy32, busy4;

    freq_meter #(.CLK_FREQ(1000), .GATE_HZ(10), .CNT_W(32)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .sig_in_i     (sig_in),
        .freq_cnt_o   (freq32),
        .valid_o      (valid32),
        .ovf_o        (ovf32),
        .busy_o       (busy32),
        .period_cnt_o (per32)
    );

    freq_meter #(.CLK_FREQ(1000), .GATE_HZ(10), .CNT_W(4)) u_dut4 (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .sig_in_i     (sig_in),
        .freq_cnt_o   (freq4),
        .valid_o      (valid4),
        .ovf_o        (ovf4),
        .busy_o       (busy4),
        .period_cnt_o (per4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_err = 0;
    int unsigned n_chk = 0;
    bit          chk_on = 1'b0;
    int          sig_hi = 0;
    int          sig_lo = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns the number of negedges up to and including the one where valid is seen.
    task automatic wait_valid(input int max_cyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid32 && n < max_cyc);
        if (!valid32) check_eq("valid_timeout", 64'(valid32), 64'(1));
    endtask

    // ---------------- reference model ----------------
    bit          m_s0, m_s1, m_s2;   // sig_in as sampled 1, 2 and 3 edges ago
    bit          m_gate;
    int          m_pos, m_edges;
    bit          m_have;
    longint      m_cyc, m_last;
    logic [63:0] e_valid, e_busy, e_freq32, e_freq4, e_ovf4, e_per32, e_per4;

    task automatic model_step();
        bit     ed;
        longint d;
        m_cyc++;
        ed      = m_s1 && !m_s2;     // detected edge trails the input rise by two clocks
        e_valid = 0;
        if (rst) begin
            m_gate = 0; m_pos = 0; m_edges = 0; m_have = 0;
            e_freq32 = 0; e_freq4 = 0; e_ovf4 = 0; e_per32 = 0; e_per4 = 0;
            m_s0 = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            if (!m_gate) begin
                if (en) begin
                    m_gate = 1; m_pos = 0; m_edges = 0;
                end
            end else if (!en) begin
                m_gate = 0;
            end else begin
                m_edges += int'(ed);
                if (m_pos == int'(G) - 1) begin
                    e_freq32 = 64'(m_edges);
                    e_freq4  = (m_edges > 15) ? 64'(15) : 64'(m_edges);
                    e_ovf4   = (m_edges > 15) ? 64'(1) : 64'(0);
                    e_valid  = 1;
                    m_pos    = 0;
                    m_edges  = 0;
                end else begin
                    m_pos++;
                end
            end
            if (!en) begin
                m_have = 0;
            end else if (ed) begin
                if (m_have && PER_EN) begin
                    d       = m_cyc - m_last;
                    e_per32 = 64'(d);
                    e_per4  = (d > 15) ? 64'(15) : 64'(d);
                end
                m_last = m_cyc;
                m_have = 1;
            end
            m_s2 = m_s1; m_s1 = m_s0; m_s0 = sig_in;
        end
        e_busy = 64'(m_gate);
    endtask

    initial begin
        m_cyc = 0; m_last = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check_eq("valid32", 64'(valid32), e_valid);
                check_eq("busy32", 64'(busy32), e_busy);
                check_eq("freq32", 64'(freq32), e_freq32);
                check_eq("ovf32", 64'(ovf32), 64'(0));
                check_eq("period32", 64'(per32), e_per32);
                check_eq("valid4", 64'(valid4), e_valid);
                check_eq("busy4", 64'(busy4), e_busy);
                check_eq("freq4", 64'(freq4), e_freq4);
                check_eq("ovf4", 64'(ovf4), e_ovf4);
                check_eq("period4", 64'(per4), e_per4);
            end
        end
    end

    // ---------------- sig_in generator ----------------
    initial begin
        int hi, lo;
        sig_in = 1'b0;
        tick(1);
        forever begin
            if (sig_hi == 0) begin
                sig_in = 1'b0;
                tick(1);
            end else begin
                hi = sig_hi;
                lo = sig_lo;
                sig_in = 1'b1;
                tick(hi);
                sig_in = 1'b0;
                tick(lo);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n, cnt, r;
        rst = 1'b1;
        en  = 1'b0;
        tick(3);
        chk_on = 1'b1;
        @(negedge clk);
        check_eq("rst_freq", 64'(freq32), 64'(0));
        check_eq("rst_valid", 64'(valid32), 64'(0));
        check_eq("rst_busy", 64'(busy32), 64'(0));
        check_eq("rst_ovf", 64'(ovf4), 64'(0));
        check_eq("rst_period", 64'(per32), 64'(0));
        tick(1);
        rst = 1'b0;
        tick(5);

        // Quiet input: first window reports zero; first negedge is in the cycle sampling en.
        en = 1'b1;
        wait_valid(250, n);
        check_eq("first_latency", 64'(n - 1), 64'(101));
        check_eq("quiet_freq", 64'(freq32), 64'(0));
        check_eq("quiet_ovf", 64'(ovf32), 64'(0));

        // Period 10 square wave.
        tick(1);
        sig_hi = 5; sig_lo = 5;
        tick(30);
        wait_valid(250, n);
        wait_valid(250, n);
        check_eq("valid_interval", 64'(n), 64'(100));
        check_eq("p10_freq", 64'(freq32), 64'(10));
        check_eq("p10_ovf", 64'(ovf32), 64'(0));
        check_eq("p10_freq4", 64'(freq4), 64'(10));
        check_eq("p10_period", 64'(per32), PER_EN ? 64'(10) : 64'(0));

        // Abort mid-window.
        tick(50);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("abort_busy", 64'(busy32), 64'(0));
        cnt = 0;
        repeat (150) begin
            @(negedge clk);
            if (valid32) cnt++;
        end
        check_eq("abort_no_valid", 64'(cnt), 64'(0));
        check_eq("abort_hold_freq", 64'(freq32), 64'(10));
        tick(1);
        en = 1'b1;
        wait_valid(250, n);
        check_eq("restart_latency", 64'(n - 1), 64'(101));
        check_eq("restart_freq", 64'(freq32), 64'(10));

        // Period 4: saturates the 4-bit counter.
        tick(1);
        sig_hi = 2; sig_lo = 2;
        tick(30);
        wait_valid(250, n);
        wait_valid(250, n);
        check_eq("p4_freq4", 64'(freq4), 64'(15));
        check_eq("p4_ovf4", 64'(ovf4), 64'(1));
        check_eq("p4_freq32", 64'(freq32), 64'(25));
        check_eq("p4_ovf32", 64'(ovf32), 64'(0));
        tick(1);
        sig_hi = 5; sig_lo = 5;
        tick(30);
        wait_valid(250, n);
        wait_valid(250, n);
        check_eq("p10b_freq4", 64'(freq4), 64'(10));
        check_eq("p10b_ovf4", 64'(ovf4), 64'(0));

        // Period 7.
        tick(1);
        sig_hi = 3; sig_lo = 4;
        tick(40);
        check_eq("p7_period32", 64'(per32), PER_EN ? 64'(7) : 64'(0));
        check_eq("p7_period4", 64'(per4), PER_EN ? 64'(7) : 64'(0));

        // Reset mid-window.
        wait_valid(250, n);
        tick(60);
        rst = 1'b1;
        tick(1);
        check_eq("midrst_freq", 64'(freq32), 64'(0));
        check_eq("midrst_valid", 64'(valid32), 64'(0));
        check_eq("midrst_ovf", 64'(ovf32), 64'(0));
        check_eq("midrst_busy", 64'(busy32), 64'(0));
        check_eq("midrst_period", 64'(per32), 64'(0));
        rst = 1'b0;

        // Randomized traffic.
        for (int s = 0; s < 40; s++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                rst = 1'b1;
                tick(int'($urandom_range(1, 3)));
                rst = 1'b0;
            end else if (r < 3) begin
                en = ~en;
            end else if (r == 3) begin
                sig_hi = 0;
            end else begin
                sig_hi = int'($urandom_range(2, 12));
                sig_lo = int'($urandom_range(2, 12));
            end
            if (!en && r != 1 && r != 2) en = 1'b1;
            tick(int'($urandom_range(20, 250)));
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
